// File: rtl/draw_sequencer.sv
// draw_sequencer
// Frame-level initiator for the draw engines that write VGA memory. Each
// frame_start runs the map engine (only when a redraw is pending), then the
// player sprite engine, then the enemy sprite engine, one at a time through
// an enable/done handshake. The active engine's pixel stream is forwarded
// onto a single registered VGA write port.
//
// Ports:
//   clock, resetn            system clock, asynchronous active-low reset
//   frame_start, map_redraw  single-cycle requests from game control
//   <eng>_enable / <eng>_done  handshake per engine (map, pl, en)
//   <eng>_x/_y/_colour/_write  engine pixel outputs (9/8/6/1 bits)
//   vga_x/y/colour/plot      registered VGA write port
//   busy, frame_done         sequencer status
//   timeout_err, overrun_err sticky error flags, cleared only by reset
module draw_sequencer #(
  parameter logic [16:0] TIMEOUT = 17'd65535
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_start,
  input  logic       map_redraw,
  output logic       map_enable,
  input  logic       map_done,
  input  logic [8:0] map_x,
  input  logic [7:0] map_y,
  input  logic [5:0] map_colour,
  input  logic       map_write,
  output logic       pl_enable,
  input  logic       pl_done,
  input  logic [8:0] pl_x,
  input  logic [7:0] pl_y,
  input  logic [5:0] pl_colour,
  input  logic       pl_write,
  output logic       en_enable,
  input  logic       en_done,
  input  logic [8:0] en_x,
  input  logic [7:0] en_y,
  input  logic [5:0] en_colour,
  input  logic       en_write,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [5:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err,
  output logic       overrun_err
);

  typedef enum logic [2:0] {
    IDLE, MAP, MAP_ACK, PL, PL_ACK, EN, EN_ACK, FIN
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] wdog_q, wdog_d, wdog_inc;
  logic        wd_hit;
  logic        map_pending_q, map_pending_d;
  logic        timeout_err_q, timeout_err_d;
  logic        overrun_err_q, overrun_err_d;
  logic        map_enable_q, map_enable_d;
  logic        pl_enable_q, pl_enable_d;
  logic        en_enable_q, en_enable_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [8:0]  vga_x_q, vga_x_d;
  logic [7:0]  vga_y_q, vga_y_d;
  logic [5:0]  vga_colour_q, vga_colour_d;
  logic        vga_plot_q, vga_plot_d;

  always_comb begin
    // Saturating increment; the hit test looks at the post-increment value
    // so an engine stays enabled for exactly TIMEOUT cycles.
    wdog_inc      = (wdog_q == '1) ? wdog_q : wdog_q + 17'd1;
    wd_hit        = (wdog_inc >= TIMEOUT);
    state_d       = state_q;
    wdog_d        = wdog_q;
    map_pending_d = map_pending_q;
    timeout_err_d = timeout_err_q;
    overrun_err_d = overrun_err_q;
    vga_x_d       = vga_x_q;
    vga_y_d       = vga_y_q;
    vga_colour_d  = vga_colour_q;
    vga_plot_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = map_pending_q ? MAP : PL;
          wdog_d  = '0;
        end
      end
      MAP: begin
        wdog_d       = wdog_inc;
        vga_x_d      = map_x;
        vga_y_d      = map_y;
        vga_colour_d = map_colour;
        vga_plot_d   = map_write;
        if (map_done) begin
          state_d       = MAP_ACK;
          map_pending_d = 1'b0;
        end else if (wd_hit) begin
          state_d       = MAP_ACK;
          timeout_err_d = 1'b1;
        end
      end
      MAP_ACK: begin
        if (!map_done) begin
          state_d = PL;
          wdog_d  = '0;
        end
      end
      PL: begin
        wdog_d       = wdog_inc;
        vga_x_d      = pl_x;
        vga_y_d      = pl_y;
        vga_colour_d = pl_colour;
        vga_plot_d   = pl_write;
        if (pl_done) begin
          state_d = PL_ACK;
        end else if (wd_hit) begin
          state_d       = PL_ACK;
          timeout_err_d = 1'b1;
        end
      end
      PL_ACK: begin
        if (!pl_done) begin
          state_d = EN;
          wdog_d  = '0;
        end
      end
      EN: begin
        wdog_d       = wdog_inc;
        vga_x_d      = en_x;
        vga_y_d      = en_y;
        vga_colour_d = en_colour;
        vga_plot_d   = en_write;
        if (en_done) begin
          state_d = EN_ACK;
        end else if (wd_hit) begin
          state_d       = EN_ACK;
          timeout_err_d = 1'b1;
        end
      end
      EN_ACK: begin
        if (!en_done) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A redraw request overrides the clear from a completed map draw.
    if (map_redraw) begin
      map_pending_d = 1'b1;
    end
    if (frame_start && busy_q) begin
      overrun_err_d = 1'b1;
    end

    // Status and enables are registered from the next state so they are
    // glitch-free and track the state register exactly.
    map_enable_d = (state_d == MAP);
    pl_enable_d  = (state_d == PL);
    en_enable_d  = (state_d == EN);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == FIN);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      wdog_q        <= '0;
      map_pending_q <= 1'b1;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      map_enable_q  <= 1'b0;
      pl_enable_q   <= 1'b0;
      en_enable_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      map_pending_q <= map_pending_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
      map_enable_q  <= map_enable_d;
      pl_enable_q   <= pl_enable_d;
      en_enable_q   <= en_enable_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      vga_plot_q    <= vga_plot_d;
    end
  end

  assign map_enable  = map_enable_q;
  assign pl_enable   = pl_enable_q;
  assign en_enable   = en_enable_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign vga_plot    = vga_plot_q;

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Frame-level initiator for the draw engines that write VGA memory. On each frame tick it enables the map engine (only when a redraw is pending), then the player sprite engine, then the enemy sprite engine, one at a time via the enable/draw_done handshake. It multiplexes the active engine's x/y/colour/write onto a single registered VGA write port. It sits between the game control FSM and the VGA adapter.

## Interface
- TIMEOUT, 17'd65535, cycles a single engine may stay enabled before it is aborted (must exceed 45057, the map draw length).
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse requesting a new frame.
- map_redraw  in  1  one-cycle pulse marking the map as needing a redraw.
- map_enable / map_done  out/in  1/1  handshake with the map engine.
- map_x, map_y, map_colour, map_write  in  9/8/6/1  map engine pixel output.
- pl_enable / pl_done, pl_x, pl_y, pl_colour, pl_write  out/in...  same widths, player sprite engine.
- en_enable / en_done, en_x, en_y, en_colour, en_write  out/in...  same widths, enemy sprite engine.
- vga_x  out  9  registered pixel x.
- vga_y  out  8  registered pixel y.
- vga_colour  out  6  registered colour.
- vga_plot  out  1  registered write enable.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame sequence ends.
- timeout_err  out  1  sticky; set when any engine is aborted.
- overrun_err  out  1  sticky; set when frame_start arrives while busy.

## Operation
- States: IDLE, MAP, MAP_ACK, PL, PL_ACK, EN, EN_ACK, FIN.
- IDLE:
  - On frame_start, go to MAP if map_pending=1, else go to PL.
  - Without frame_start, stay in IDLE.
- MAP/PL/EN:
  - Assert only that engine's enable. Enables are registered: high exactly while in the state.
  - Leave on done=1 or when the watchdog reaches TIMEOUT, moving to the matching _ACK state.
- _ACK states:
  - All enables are low for one cycle, so the engine can clear draw_done.
  - Then advance MAP_ACK->PL, PL_ACK->EN, EN_ACK->FIN.
  - If the engine's done is still 1 in the _ACK cycle, hold in _ACK until it falls.
- FIN: pulse frame_done for one cycle, then go to IDLE.
- map_pending:
  - Reset value is 1, so the first frame always draws the map.
  - map_redraw sets it.
  - A normal (done, not timeout) exit from MAP clears it.
  - If set and clear occur in the same cycle, set wins.
  - A timeout exit from MAP leaves it set.
- Watchdog:
  - 17-bit counter, cleared on entry to each drawing state, incremented each cycle in that state.
  - At TIMEOUT: set timeout_err and exit as if done.
  - The counter saturates and never wraps.
- Mux:
  - In MAP/PL/EN the next vga_* values are that engine's x/y/colour/write.
  - In all other states vga_plot is 0 and x/y/colour hold their previous values.
- Errors:
  - frame_start while busy=1 is ignored and sets overrun_err.
  - Both sticky flags clear only on reset.
  - frame_start in the same cycle as the FIN->IDLE transition is ignored and counts as overrun.

## Timing
- Reset (resetn=0, takes effect immediately):
  - State = IDLE.
  - All enables = 0; vga_x, vga_y, vga_colour, vga_plot = 0.
  - busy, frame_done, timeout_err, overrun_err = 0; map_pending = 1.
- frame_start sampled at edge N -> enable high after edge N (visible in cycle N+1).
- VGA port latency: 1 cycle from engine outputs to vga_* outputs.
- Engine done sampled at edge M -> enable low after M; an engine write in cycle M is still forwarded.
- Per-engine overhead: 1 ACK cycle, or more if done stays high. FIN adds 1 cycle.
- Frame with map (45057-cycle engine), 10-cycle sprites, all done pulses clearing promptly:
  - Map: 45057 + 1 ACK.
  - Each sprite: 10 + 1 ACK.
  - Plus 1 FIN cycle.
- Reset mid-sequence: all enables drop asynchronously and no frame_done is produced.

## Test plan
- Reset then frame_start:
  - map_enable high for 45057 cycles.
  - pl_enable, then en_enable, each high for the length of its stub.
  - frame_done pulses once; map_pending = 0 afterwards.
- Second frame_start without map_redraw -> map_enable never rises; PL then EN run; frame_done pulses.
- map_redraw pulsed during MAP, in the same cycle map_done=1 -> map_pending stays 1; the next frame redraws the map.
- Player stub never asserts done, TIMEOUT=100 -> pl_enable is high exactly 100 cycles; timeout_err=1; EN still runs; frame_done pulses.
- frame_start during EN -> overrun_err=1; the sequence is unchanged; exactly one frame_done.
- Enemy stub holds done high 3 cycles after enable drops -> FSM stays in EN_ACK for those cycles; vga_plot = 0 throughout; then FIN.
- resetn low mid-MAP -> all outputs 0 within the same cycle; the next frame_start draws the map again.
